// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared types and parameter defaults for the step controller
// Purpose: FSM state encoding and default timing constants used by step_controller
//          and its debouncer.
// Ports:   none (package).
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } step_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_RATE     = 5000000;

endpackage

// File: rtl/step_controller_debouncer.sv
// rtl/step_controller_debouncer.sv - 2-flop synchronizer plus stability-count debouncer
// Purpose: brings one raw asynchronous button into the clk domain and only accepts
//          a level change after it has persisted for DEBOUNCE_CYCLES cycles.
// Ports:   clk   - system clock
//          rst   - asynchronous active-high reset
//          raw   - raw asynchronous button input
//          level - debounced, synchronous button level
module debouncer
  import step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      // Any cycle of agreement restarts the stability window.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/step_controller.sv
// rtl/step_controller.sv - button-driven step strobe generator with auto-repeat
// Purpose: turns up/down push buttons into single-cycle step strobes for an up/down
//          counter, with a delayed auto-repeat while a button stays held and a lockout
//          when both buttons are pressed.
// Ports:   clk    - system clock
//          rst    - asynchronous active-high reset
//          btn_up - raw "count up" button
//          btn_dn - raw "count down" button
//          en     - registered one-cycle step strobe
//          mode   - registered step direction (1 = up, 0 = down)
//          held   - high while in HOLD or REPEAT
module step_controller
  import step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  output logic en,
  output logic mode,
  output logic held
);

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic up_lvl;
  logic dn_lvl;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (up_lvl)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dn),
    .level (dn_lvl)
  );

  step_state_e   state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          mode_q, mode_d;
  logic          active;
  logic          opposite;

  // mode_q records the direction of the button that started the current hold.
  assign active   = mode_q ? up_lvl : dn_lvl;
  assign opposite = mode_q ? dn_lvl : up_lvl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (up_lvl && dn_lvl) begin
          state_d = ST_LOCK;
        end else if (up_lvl || dn_lvl) begin
          en_d    = 1'b1;
          mode_d  = up_lvl;
          cnt_d   = RW'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        // cnt_q holds the number of edges since the last pulse, starting at 1.
        if (!active) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (opposite) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == ((state_q == ST_HOLD) ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE))) begin
          en_d    = 1'b1;
          cnt_d   = RW'(1);
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end
      ST_LOCK: begin
        cnt_d = '0;
        if (!up_lvl && !dn_lvl) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      mode_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
    end
  end

  assign en   = en_q;
  assign mode = mode_q;
  assign held = (state_q == ST_HOLD) || (state_q == ST_REPEAT);

endmodule

// File: tb/tb_step_controller.sv
// tb/tb_step_controller.sv - directed self-checking bench for step_controller
module tb_step_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic en;
  logic mode;
  logic held;

  int n_tests = 0;
  int n_fail  = 0;

  step_controller #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .en     (en),
    .mode   (mode),
    .held   (held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [127:0] b(input int k);
    logic [127:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Bit e of each pattern is the value driven before / expected after edge e.
  task automatic run_scn(input string name, input int n,
                         input logic [127:0] up_p, input logic [127:0] dn_p,
                         input logic [127:0] rst_p, input logic [127:0] en_p,
                         input logic [127:0] held_p, input logic [127:0] mode_p);
    for (int e = 0; e < n; e++) begin
      btn_up = up_p[e];
      btn_dn = dn_p[e];
      rst    = rst_p[e];
      @(posedge clk);
      #1;
      chk($sformatf("%s en@%0d", name, e), {31'd0, en}, {31'd0, en_p[e]});
      chk($sformatf("%s held@%0d", name, e), {31'd0, held}, {31'd0, held_p[e]});
      chk($sformatf("%s mode@%0d", name, e), {31'd0, mode}, {31'd0, mode_p[e]});
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] bounce;
    ones = '1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset en", {31'd0, en}, 32'd0);
    chk("reset mode", {31'd0, mode}, 32'd1);
    chk("reset held", {31'd0, held}, 32'd0);
    rst = 1'b0;

    // Up held: initial pulse, delayed first repeat, then steady rate.
    do_reset();
    run_scn("up_hold", 30, ones, '0, '0,
            b(7) | b(17) | b(20) | b(23) | b(26) | b(29),
            rng(7, 127), ones);

    // Down toggling every 2 cycles never settles long enough.
    bounce = '0;
    for (int e = 0; e < 40; e++) bounce[e] = ((e / 2) % 2) == 0;
    do_reset();
    run_scn("dn_bounce", 44, '0, bounce, '0, '0, '0, ones);

    // Short down press: one pulse, released before the repeat delay expires.
    do_reset();
    run_scn("dn_short", 25, '0, rng(0, 7), '0, b(7), rng(7, 14), rng(0, 6));

    // Up held, down added: lock out, then a fresh down press after both released.
    do_reset();
    run_scn("lock_add", 50, rng(0, 24), rng(9, 24) | rng(40, 127), '0,
            b(7) | b(47), rng(7, 15) | rng(47, 127), rng(0, 46));

    // Both together: locked until both are low, even with one already released.
    do_reset();
    run_scn("both", 45, rng(0, 11) | rng(34, 127), rng(0, 23), '0,
            b(41), rng(41, 127), ones);

    // Reset during repeat with up held: aborted, then re-debounced as a new press.
    do_reset();
    run_scn("rst_up", 30, ones, '0, b(18) | b(19),
            b(7) | b(17) | b(27), rng(7, 17) | rng(27, 127), ones);

    // Reset during hold with down held: mode forced back to 1 during reset.
    do_reset();
    run_scn("rst_dn", 22, '0, ones, b(10) | b(11),
            b(7) | b(19), rng(7, 9) | rng(19, 127), rng(0, 6) | rng(10, 18));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
